// File: rtl/design_out_misr.sv
// Output-compaction MISR: after an optional settle period, folds WINDOW samples of
// the upstream output word into a signature and counts sample-to-sample changes.
module design_out_misr #(
  parameter int               WIDTH  = 32,
  parameter int               WINDOW = 64,
  parameter int               SETTLE = 10,
  parameter logic [WIDTH-1:0] POLY   = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] sig,
  output logic             sig_valid,
  output logic [15:0]      toggles
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  localparam bit          HAS_SETTLE  = (SETTLE > 0);
  localparam logic [7:0]  SETTLE_LOAD = 8'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [15:0] LAST_SAMPLE = 16'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [7:0]       settle_cnt;
  logic [15:0]      sample_cnt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] sig_nxt;

  assign sig_nxt   = (sig << 1) ^ (sig[WIDTH-1] ? POLY : '0) ^ in;
  assign busy      = (state == ST_SETTLE) || (state == ST_ACCUM);
  assign sig_valid = (state == ST_DONE);

  // A start pulse restarts the run from any state, so it is tested before the case.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = HAS_SETTLE ? ST_SETTLE : ST_ACCUM;
    end else begin
      case (state)
        ST_SETTLE: if (settle_cnt == 8'd0) state_nxt = ST_ACCUM;
        ST_ACCUM:  if (sample_cnt == LAST_SAMPLE) state_nxt = ST_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sig        <= '0;
      toggles    <= 16'd0;
      prev       <= '0;
      sample_cnt <= 16'd0;
      settle_cnt <= 8'd0;
    end else if (start) begin
      sig        <= '0;
      toggles    <= 16'd0;
      prev       <= '0;
      sample_cnt <= 16'd0;
      settle_cnt <= SETTLE_LOAD;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        end
        ST_ACCUM: begin
          sig        <= sig_nxt;
          prev       <= in;
          sample_cnt <= sample_cnt + 16'd1;
          // Saturate rather than wrap so a huge window never reports a small count.
          if ((in != prev) && (toggles != 16'hFFFF)) toggles <= toggles + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_design_out_misr.sv
// Bench for design_out_misr: three parameterisations driven with directed and
// random runs, checked against a sample-list model of the signature and toggles.
module tb_design_out_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_v [3];
  logic [31:0] in_v    [3];
  logic        busy_v  [3];
  logic [31:0] sig_v   [3];
  logic        valid_v [3];
  logic [15:0] tog_v   [3];

  int settleOf [3] = '{2, 0, 2};
  int windowOf [3] = '{8, 1, 2};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  design_out_misr #(.WIDTH(32), .WINDOW(8), .SETTLE(2), .POLY(POLY)) u_main (
    .clk(clk), .rst(rst), .in(in_v[0]), .start(start_v[0]),
    .busy(busy_v[0]), .sig(sig_v[0]), .sig_valid(valid_v[0]), .toggles(tog_v[0])
  );

  design_out_misr #(.WIDTH(32), .WINDOW(1), .SETTLE(0), .POLY(POLY)) u_w1 (
    .clk(clk), .rst(rst), .in(in_v[1]), .start(start_v[1]),
    .busy(busy_v[1]), .sig(sig_v[1]), .sig_valid(valid_v[1]), .toggles(tog_v[1])
  );

  design_out_misr #(.WIDTH(32), .WINDOW(2), .SETTLE(2), .POLY(POLY)) u_w2 (
    .clk(clk), .rst(rst), .in(in_v[2]), .start(start_v[2]),
    .busy(busy_v[2]), .sig(sig_v[2]), .sig_valid(valid_v[2]), .toggles(tog_v[2])
  );

  // vals[c] is the word on in during cycle c, where cycle 0 carries the start pulse;
  // the samples compacted are those of cycles S+1 .. S+W.
  function automatic void model(input logic [31:0] vals[$], input int s, input int w,
                                output logic [31:0] esig, output logic [15:0] etog);
    logic [31:0] prevw;
    logic [31:0] x;
    prevw = 32'h0;
    esig  = 32'h0;
    etog  = 16'h0;
    for (int k = s + 1; k <= s + w; k++) begin
      x    = (k < vals.size()) ? vals[k] : 32'h0;
      esig = (esig << 1) ^ (esig[31] ? POLY : 32'h0) ^ x;
      if (x != prevw && etog != 16'hFFFF) etog = etog + 16'h1;
      prevw = x;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic st, input logic [31:0] v);
    @(negedge clk);
    start_v[id] = st;
    in_v[id]    = v;
  endtask

  task automatic checkIdle(input int id, input string tag);
    checkOutput({tag, " busy"},    {31'b0, busy_v[id]},  32'h0);
    checkOutput({tag, " valid"},   {31'b0, valid_v[id]}, 32'h0);
    checkOutput({tag, " sig"},     sig_v[id],            32'h0);
    checkOutput({tag, " toggles"}, {16'b0, tog_v[id]},   32'h0);
  endtask

  task automatic runWindow(input int id, input logic [31:0] vals[$], input string tag);
    int          s;
    int          w;
    logic [31:0] esig;
    logic [15:0] etog;
    s = settleOf[id];
    w = windowOf[id];
    model(vals, s, w, esig, etog);
    applyStimulus(id, 1'b1, vals[0]);
    for (int c = 1; c <= s + w + 1; c++) begin
      applyStimulus(id, 1'b0, (c < vals.size()) ? vals[c] : 32'h0);
      checkOutput($sformatf("%s valid c%0d", tag, c), {31'b0, valid_v[id]}, {31'b0, (c == s + w + 1)});
      checkOutput($sformatf("%s busy c%0d", tag, c),  {31'b0, busy_v[id]},  {31'b0, (c <= s + w)});
      if (c == 1) begin
        checkOutput({tag, " cleared sig"},     sig_v[id],          32'h0);
        checkOutput({tag, " cleared toggles"}, {16'b0, tog_v[id]}, 32'h0);
      end
    end
    checkOutput({tag, " sig"},     sig_v[id],          esig);
    checkOutput({tag, " toggles"}, {16'b0, tog_v[id]}, {16'b0, etog});
  endtask

  initial begin
    logic [31:0] vals[$];
    logic [31:0] held_sig;
    logic [15:0] held_tog;

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      in_v[i]    = 32'h0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) checkIdle(i, $sformatf("reset inst%0d", i));
    rst = 1'b1;

    // All-zero input gives a zero signature with sig_valid 11 cycles after start.
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back(32'h0);
    runWindow(0, vals, "zeros");
    checkOutput("zeros literal", sig_v[0], 32'h0);

    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back(k == 3 ? 32'h1 : 32'h0);
    runWindow(0, vals, "single one");
    checkOutput("single one literal sig", sig_v[0], 32'h00000080);
    checkOutput("single one literal tog", {16'b0, tog_v[0]}, 32'd2);

    vals = {};
    for (int k = 0; k < 4; k++) vals.push_back(32'haaaaaaaa);
    runWindow(1, vals, "w1 aaaa");
    checkOutput("w1 literal sig", sig_v[1], 32'haaaaaaaa);
    checkOutput("w1 literal tog", {16'b0, tog_v[1]}, 32'd1);

    vals = {};
    for (int k = 0; k < 6; k++) vals.push_back(k == 3 ? 32'h80000000 : 32'h0);
    runWindow(2, vals, "w2 feedback");
    checkOutput("w2 literal sig", sig_v[2], 32'h04C11DB7);

    for (int r = 0; r < 4; r++) begin
      vals = {};
      for (int k = 0; k < 12; k++) begin
        if (k > 0 && $urandom_range(0, 2) == 0) vals.push_back(vals[k-1]);
        else vals.push_back($urandom);
      end
      runWindow(0, vals, $sformatf("random%0d", r));
    end

    // DONE holds its result while in wanders, then a restart discards it.
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back(32'habcdefab);
    runWindow(0, vals, "pre restart");
    held_sig = sig_v[0];
    held_tog = tog_v[0];
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b0, $urandom);
      checkOutput("done hold sig",   sig_v[0],           held_sig);
      checkOutput("done hold tog",   {16'b0, tog_v[0]},  {16'b0, held_tog});
      checkOutput("done hold valid", {31'b0, valid_v[0]}, 32'h1);
    end
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back(32'h12345678);
    runWindow(0, vals, "post restart");

    // Restart in the middle of ACCUM and of SETTLE.
    applyStimulus(0, 1'b1, 32'h0);
    for (int c = 1; c <= settleOf[0] + 3; c++) applyStimulus(0, 1'b0, $urandom);
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back($urandom);
    runWindow(0, vals, "restart accum");
    applyStimulus(0, 1'b1, $urandom);
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back($urandom);
    runWindow(0, vals, "restart settle");

    // Reset during the fourth ACCUM sample aborts the run for good.
    applyStimulus(0, 1'b1, 32'h0);
    for (int c = 1; c <= settleOf[0] + 3; c++) applyStimulus(0, 1'b0, $urandom);
    @(negedge clk);
    rst = 1'b0;
    in_v[0] = $urandom;
    @(negedge clk);
    rst = 1'b1;
    checkIdle(0, "abort");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1'b0, $urandom);
      checkIdle(0, $sformatf("abort idle%0d", k));
    end
    vals = {};
    for (int k = 0; k < 12; k++) vals.push_back(32'h0);
    runWindow(0, vals, "after abort");
    checkOutput("after abort literal", sig_v[0], 32'h0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst        = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst        = 1'b1;
    start_v[0] = 1'b0;
    checkIdle(0, "rst over start");
    applyStimulus(0, 1'b0, $urandom);
    checkIdle(0, "rst over start later");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
